alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Upstream/downstream companion to the 4-bit ALU datapath.
- Accepts ALU commands (opcode, A, B) over a valid/ready interface.
- Buffers commands in a small FIFO.
- Issues one command per cycle to the ALU over combinational operand/opcode outputs.
- Registers the ALU's Result/Flag into a response slot with its own valid/ready handshake.
- Turns the combinational ALU into a pipelined, back-pressurable unit.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- CNT_W, 3, width of fifo_count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_opcode  in  3  ALU opcode: 000 add, 001 sub, 010 or, 011 and, 100 xor, others give result 0.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- alu_opcode  out  3  opcode to ALU.
- alu_a  out  4  operand A to ALU.
- alu_b  out  4  operand B to ALU.
- alu_result  in  4  ALU Result, combinational from alu_*.
- alu_flag  in  1  ALU Flag (carry/borrow).
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_result  out  4  registered result.
- rsp_flag  out  1  registered flag.
- fifo_count  out  CNT_W  entries currently buffered.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset values:
  - FIFO pointers are 0.
  - fifo_count = 0, rsp_valid = 0, rsp_result = 0, rsp_flag = 0.
  - cmd_ready = 1 in the first cycle after reset release.
- Reset mid-operation: discards all buffered commands and any pending response. No partial state survives.
- Push: push = cmd_valid & cmd_ready. cmd_ready = (fifo_count != DEPTH). cmd_ready depends only on state, never on cmd_valid.
- Full FIFO: a push is not accepted in the same cycle as a pop. There is no pass-through; cmd_ready stays 0 for the whole cycle.
- ALU drive: alu_opcode, alu_a and alu_b always show the FIFO head entry. When the FIFO is empty they show all zeros.
- Issue (pop): issue = (fifo_count != 0) & (!rsp_valid | rsp_ready).
- On issue, at the clock edge:
  - rsp_result <= alu_result and rsp_flag <= alu_flag.
  - rsp_valid <= 1.
  - The read pointer advances.
- Response consumed without a new issue: if rsp_valid & rsp_ready & !issue, then rsp_valid <= 0 and rsp_result/rsp_flag hold their values.
- Response stall: rsp_valid = 1 and rsp_ready = 0 means rsp_result/rsp_flag are held stable and there is no issue.
- Latency: a command accepted at edge N into an empty FIFO, with the slot free, gives rsp_valid = 1 after edge N+1. That is 2 cycles from cmd_valid sampling to rsp_valid.
- Throughput: one command per cycle when rsp_ready is held at 1.
- fifo_count update: +1 on push only, -1 on issue only, unchanged on both or neither.
- Pointer wrap: pointers are log2(DEPTH) bits wide and wrap naturally modulo DEPTH.
- Ordering: responses appear strictly in command order. None are dropped or duplicated.

Optional Feature:
Macro: ALU_CHAIN_EN.
- Defined:
  - Adds input port cmd_chain (1 bit), stored per FIFO entry.
  - Adds an internal register last_result (4 bits, reset 0), updated with alu_result on every issue.
  - When the head entry has chain = 1, alu_a is driven from last_result instead of the stored A.
  - last_result always holds the result of the immediately preceding issued command, so back-to-back chaining works at full rate.
- Not defined: no cmd_chain port, no last_result register, and alu_a always carries the stored A.

Test Plan:
- Reset, then push add A=9 B=8 with rsp_ready=1 -> rsp_valid two cycles later, rsp_result=0001, rsp_flag=1. fifo_count returns to 0.
- Push sub A=3 B=5, then xor A=A B=5 -> responses in order: result 1110 flag 1, then result 1111 flag 0.
- Hold rsp_ready=0 and push 5 commands with DEPTH=4 -> one response held stable, cmd_ready=0 at fifo_count=4. Releasing rsp_ready drains all 5 in order at 1 per cycle.
- Push opcode 111 A=F B=F -> rsp_result=0000, rsp_flag=0.
- Assert rst_n=0 with 3 commands buffered and rsp_valid=1 -> next cycle rsp_valid=0, fifo_count=0, cmd_ready=1. No stale response appears afterwards.
- ALU_CHAIN_EN: add A=2 B=3, then chained add B=4, then chained sub B=1 -> responses 0101, 1001, 1000 (flag 0).

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus registered response slot that turns a combinational 4-bit ALU into a
// back-pressurable pipelined unit. Optional macro ALU_CHAIN_EN feeds the previous result into A.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opcode,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
`ifdef ALU_CHAIN_EN
  input  logic             cmd_chain,
`endif
  output logic [2:0]       alu_opcode,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [3:0]       alu_result,
  input  logic             alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_flag,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [2:0]       op_mem [DEPTH];
  logic [3:0]       a_mem  [DEPTH];
  logic [3:0]       b_mem  [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic             vld_p1;
  logic [3:0]       result_p1;
  logic             flag_p1;
  logic             push, issue, empty;
`ifdef ALU_CHAIN_EN
  logic             chain_mem [DEPTH];
  logic [3:0]       last_result;
`endif

  // Stage p0: command capture into the FIFO
  assign cmd_ready = (count != CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign push      = cmd_valid & cmd_ready;
  assign issue     = !empty & (!vld_p1 | rsp_ready);

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wptr] <= cmd_opcode;
      a_mem[wptr]  <= cmd_a;
      b_mem[wptr]  <= cmd_b;
`ifdef ALU_CHAIN_EN
      chain_mem[wptr] <= cmd_chain;
`endif
    end
  end

  // Head entry drives the ALU directly; an empty FIFO presents all zeros
  always_comb begin
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    if (!empty) begin
      alu_opcode = op_mem[rptr];
      alu_a      = a_mem[rptr];
      alu_b      = b_mem[rptr];
`ifdef ALU_CHAIN_EN
      if (chain_mem[rptr]) alu_a = last_result;
`endif
    end
  end

  // Stage p1: response slot, filled on issue and emptied when consumed with nothing behind it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      flag_p1   <= 1'b0;
    end else begin
      if (push)  wptr <= wptr + PTR_W'(1);
      if (issue) rptr <= rptr + PTR_W'(1);
      if (push && !issue)      count <= count + CNT_W'(1);
      else if (!push && issue) count <= count - CNT_W'(1);
      if (issue) begin
        vld_p1    <= 1'b1;
        result_p1 <= alu_result;
        flag_p1   <= alu_flag;
      end else if (rsp_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

`ifdef ALU_CHAIN_EN
  always_ff @(posedge clk) begin
    if (!rst_n)     last_result <= '0;
    else if (issue) last_result <= alu_result;
  end
`endif

  assign rsp_valid  = vld_p1;
  assign rsp_result = result_p1;
  assign rsp_flag   = flag_p1;
  assign fifo_count = count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: bench-side ALU, queue-based reference model and directed/random scenarios.
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_opcode = '0;
  logic [3:0]       cmd_a = '0;
  logic [3:0]       cmd_b = '0;
  logic             cmd_chain = 1'b0;
  logic [2:0]       alu_opcode;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [3:0]       alu_result;
  logic             alu_flag;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [3:0]       rsp_result;
  logic             rsp_flag;
  logic [CNT_W-1:0] fifo_count;

  int vectors = 0;
  int miscompares = 0;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
`ifdef ALU_CHAIN_EN
    .cmd_chain(cmd_chain),
`endif
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flag(rsp_flag),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // 4-bit ALU: returns {flag, result}
  function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    case (op)
      3'd0:    s = {1'b0, a} + {1'b0, b};
      3'd1:    s = {(a < b), 4'(a - b)};
      3'd2:    s = {1'b0, a | b};
      3'd3:    s = {1'b0, a & b};
      3'd4:    s = {1'b0, a ^ b};
      default: s = 5'd0;
    endcase
    return s;
  endfunction

  always_comb {alu_flag, alu_result} = alu_ref(alu_opcode, alu_a, alu_b);

  // Reference model: queue of accepted-but-unissued commands and one response slot
  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       flg;
  } exp_t;

  exp_t       fq[$];
  exp_t       slot;
  exp_t       m_e;
  bit         slot_v = 0;
  bit         armed = 0;
  bit         m_iss, m_psh, m_chain;
  logic [3:0] m_last = '0;
  logic [4:0] m_r;

  always @(negedge clk) begin
    if (armed) begin
      vectors++; if (cmd_ready !== (fq.size() != DEPTH)) begin miscompares++; $display("FAIL mon_cmd_ready got %b want %b", cmd_ready, fq.size() != DEPTH); end
      vectors++; if (fifo_count !== CNT_W'(fq.size())) begin miscompares++; $display("FAIL mon_fifo_count got %0d want %0d", fifo_count, fq.size()); end
      vectors++; if (rsp_valid !== slot_v) begin miscompares++; $display("FAIL mon_rsp_valid got %b want %b", rsp_valid, slot_v); end
      if (slot_v) begin
        vectors++; if ({rsp_flag, rsp_result} !== {slot.flg, slot.res}) begin miscompares++; $display("FAIL mon_rsp got flag=%b res=%h want flag=%b res=%h", rsp_flag, rsp_result, slot.flg, slot.res); end
      end
      if (fq.size() != 0) m_e = fq[0]; else m_e = '0;
      vectors++; if ({alu_opcode, alu_a, alu_b} !== {m_e.op, m_e.a, m_e.b}) begin miscompares++; $display("FAIL mon_alu_drive got %h/%h/%h want %h/%h/%h", alu_opcode, alu_a, alu_b, m_e.op, m_e.a, m_e.b); end
    end
    if (!rst_n) begin
      fq.delete();
      slot_v = 0;
      m_last = '0;
      armed  = 1;
    end else if (armed) begin
      m_iss = (fq.size() != 0) && (!slot_v || rsp_ready);
      m_psh = cmd_valid && (fq.size() != DEPTH);
      if (m_iss) begin
        slot   = fq.pop_front();
        slot_v = 1;
      end else if (slot_v && rsp_ready) begin
        slot_v = 0;
      end
      if (m_psh) begin
`ifdef ALU_CHAIN_EN
        m_chain = cmd_chain;
`else
        m_chain = 0;
`endif
        m_e.op  = cmd_opcode;
        m_e.a   = m_chain ? m_last : cmd_a;
        m_e.b   = cmd_b;
        m_r     = alu_ref(m_e.op, m_e.a, m_e.b);
        m_e.res = m_r[3:0];
        m_e.flg = m_r[4];
        m_last  = m_r[3:0];
        fq.push_back(m_e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    vectors++; if (fifo_count !== '0) begin miscompares++; $display("FAIL reset_fifo_count got %0d want 0", fifo_count); end
    vectors++; if ({rsp_flag, rsp_result} !== 5'd0) begin miscompares++; $display("FAIL reset_rsp got %b%h want 0", rsp_flag, rsp_result); end
    vectors++; if ({alu_opcode, alu_a, alu_b} !== 11'd0) begin miscompares++; $display("FAIL reset_alu_drive got %h want 0", {alu_opcode, alu_a, alu_b}); end
  endtask

  task automatic test_add_latency();
    rsp_ready = 1'b1;
    drive(3'd0, 4'd9, 4'd8);
    tick();
    cmd_valid = 1'b0;
    vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL lat_count1 got %0d want 1", fifo_count); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL lat_early_valid got %b want 0", rsp_valid); end
    tick();
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL lat_valid got %b want 1", rsp_valid); end
    vectors++; if ({rsp_flag, rsp_result} !== 5'b1_0001) begin miscompares++; $display("FAIL lat_add got flag=%b res=%b want flag=1 res=0001", rsp_flag, rsp_result); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL lat_count0 got %0d want 0", fifo_count); end
    tick();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL lat_consumed got %b want 0", rsp_valid); end
  endtask

  task automatic test_order();
    rsp_ready = 1'b1;
    drive(3'd1, 4'd3, 4'd5);
    tick();
    drive(3'd4, 4'hA, 4'd5);
    tick();
    vectors++; if ({rsp_valid, rsp_flag, rsp_result} !== 6'b1_1_1110) begin miscompares++; $display("FAIL order_sub got v=%b flag=%b res=%b want v=1 flag=1 res=1110", rsp_valid, rsp_flag, rsp_result); end
    cmd_valid = 1'b0;
    tick();
    vectors++; if ({rsp_valid, rsp_flag, rsp_result} !== 6'b1_0_1111) begin miscompares++; $display("FAIL order_xor got v=%b flag=%b res=%b want v=1 flag=0 res=1111", rsp_valid, rsp_flag, rsp_result); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_r [5];
    logic [2:0] op;
    logic [3:0] a, b;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      op = 3'($urandom_range(0, 4)); a = 4'($urandom); b = 4'($urandom);
      exp_r[i] = alu_ref(op, a, b);
      drive(op, a, b);
      tick();
    end
    drive(3'd0, 4'd1, 4'd1);
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full_ready got %b want 0", cmd_ready); end
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL b2b_full_count got %0d want 4", fifo_count); end
    repeat (3) tick();
    vectors++; if ({rsp_valid, rsp_flag, rsp_result} !== {1'b1, exp_r[0]}) begin miscompares++; $display("FAIL b2b_stall got %b%b%h want 1%b%h", rsp_valid, rsp_flag, rsp_result, exp_r[0][4], exp_r[0][3:0]); end
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL b2b_no_push_when_full got %0d want 4", fifo_count); end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      vectors++; if ({rsp_valid, rsp_flag, rsp_result} !== {1'b1, exp_r[i]}) begin miscompares++; $display("FAIL b2b_drain%0d got %b%b%h want 1%b%h", i, rsp_valid, rsp_flag, rsp_result, exp_r[i][4], exp_r[i][3:0]); end
    end
    tick();
    vectors++; if ({rsp_valid, fifo_count} !== 4'd0) begin miscompares++; $display("FAIL b2b_empty got v=%b cnt=%0d want v=0 cnt=0", rsp_valid, fifo_count); end
  endtask

  task automatic test_unused_op();
    rsp_ready = 1'b1;
    drive(3'd7, 4'hF, 4'hF);
    tick();
    cmd_valid = 1'b0;
    tick();
    vectors++; if ({rsp_valid, rsp_flag, rsp_result} !== 6'b1_0_0000) begin miscompares++; $display("FAIL unused_op got v=%b flag=%b res=%b want v=1 flag=0 res=0000", rsp_valid, rsp_flag, rsp_result); end
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(3'($urandom_range(0, 4)), 4'($urandom), 4'($urandom));
      tick();
    end
    cmd_valid = 1'b0;
    vectors++; if ({rsp_valid, fifo_count} !== {1'b1, 3'd3}) begin miscompares++; $display("FAIL mid_setup got v=%b cnt=%0d want v=1 cnt=3", rsp_valid, fifo_count); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++; if ({rsp_valid, fifo_count, cmd_ready} !== {1'b0, 3'd0, 1'b1}) begin miscompares++; $display("FAIL mid_reset got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1", rsp_valid, fifo_count, cmd_ready); end
    vectors++; if ({rsp_flag, rsp_result} !== 5'd0) begin miscompares++; $display("FAIL mid_reset_rsp got %b%h want 0", rsp_flag, rsp_result); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale%0d got v=%b want 0", i, rsp_valid); end
    end
  endtask

`ifdef ALU_CHAIN_EN
  task automatic test_chain();
    rsp_ready = 1'b1;
    cmd_chain = 1'b0; drive(3'd0, 4'd2, 4'd3);
    tick();
    cmd_chain = 1'b1; drive(3'd0, 4'($urandom), 4'd4);
    tick();
    vectors++; if ({rsp_flag, rsp_result} !== 5'b0_0101) begin miscompares++; $display("FAIL chain1 got flag=%b res=%b want 0 0101", rsp_flag, rsp_result); end
    drive(3'd1, 4'($urandom), 4'd1);
    tick();
    vectors++; if ({rsp_flag, rsp_result} !== 5'b0_1001) begin miscompares++; $display("FAIL chain2 got flag=%b res=%b want 0 1001", rsp_flag, rsp_result); end
    cmd_valid = 1'b0; cmd_chain = 1'b0;
    tick();
    vectors++; if ({rsp_valid, rsp_flag, rsp_result} !== 6'b1_0_1000) begin miscompares++; $display("FAIL chain3 got v=%b flag=%b res=%b want 1 0 1000", rsp_valid, rsp_flag, rsp_result); end
    tick();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cmd_valid  = ($urandom_range(0, 3) != 0);
      cmd_opcode = 3'($urandom_range(0, 7));
      cmd_a      = 4'($urandom);
      cmd_b      = 4'($urandom);
      cmd_chain  = 1'($urandom);
      rsp_ready  = (i % 150 < 75) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (DEPTH + 3) tick();
    vectors++; if ({rsp_valid, fifo_count} !== 4'd0) begin miscompares++; $display("FAIL rand_drain got v=%b cnt=%0d want 0", rsp_valid, fifo_count); end
    vectors++; if (fq.size() != 0) begin miscompares++; $display("FAIL rand_model_left got %0d want 0", fq.size()); end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_order();
    test_back_to_back();
    test_unused_op();
    test_reset_mid();
`ifdef ALU_CHAIN_EN
    test_chain();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
